updown_mod_counter: RTL
=======================

UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
- REQ-001: Parameter WIDTH SHALL default to 8; it sets the counter, load_value and step width in bits (minimum 2).
- REQ-002: Parameter MAX_VALUE SHALL default to 2**WIDTH-1; it is the terminal count, 1 <= MAX_VALUE <= 2**WIDTH-1.
- REQ-003: Parameter SATURATE SHALL default to 0; 0 selects wrap mode, 1 selects saturate mode.
- REQ-004: clk  input  1  single clock; all state updates on its rising edge.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: enable  input  1  count enable.
- REQ-007: up  input  1  count-up request.
- REQ-008: down  input  1  count-down request.
- REQ-009: load  input  1  synchronous load strobe.
- REQ-010: load_value  input  WIDTH  value loaded on load.
- REQ-011: step  input  WIDTH  increment/decrement magnitude.
- REQ-012: counter  output  WIDTH  registered count value.
- REQ-013: at_max  output  1  high when counter == MAX_VALUE (combinational from register).
- REQ-014: at_min  output  1  high when counter == 0 (combinational from register).
- REQ-015: wrap  output  1  registered one-cycle pulse: a wrap (wrap mode) or clamp (saturate mode) occurred on the update that produced the current counter value.

Function
- REQ-016: Per edge, priority SHALL be reset > load > count > hold.
- REQ-017: load=1 SHALL set counter to min(load_value, MAX_VALUE), regardless of enable/up/down; wrap=0.
- REQ-018: Count SHALL occur only when enable=1 and exactly one of up/down is 1; up=down=1 or both 0 SHALL hold counter, wrap=0.
- REQ-019: Effective step SHALL be min(step, MAX_VALUE); effective step 0 SHALL hold counter with wrap=0.
- REQ-020: Arithmetic SHALL use WIDTH+1-bit intermediates; no intermediate truncation.
- REQ-021: Wrap mode up: if counter+s > MAX_VALUE, counter <= counter+s-(MAX_VALUE+1) and wrap=1; else counter <= counter+s.
- REQ-022: Wrap mode down: if s > counter, counter <= counter+(MAX_VALUE+1)-s and wrap=1; else counter <= counter-s.
- REQ-023: Saturate mode up: if counter+s > MAX_VALUE, counter <= MAX_VALUE, wrap=1 (including when already at MAX_VALUE); else counter+s.
- REQ-024: Saturate mode down: if s > counter, counter <= 0, wrap=1; else counter-s.
- REQ-025: Counter SHALL never hold a value > MAX_VALUE.
- REQ-026: Latency SHALL be one cycle: inputs sampled at edge N appear on counter/wrap after edge N.

Reset
- REQ-027: reset=1 at an edge SHALL set counter=0, wrap=0 (hence at_min=1, at_max=0 unless MAX_VALUE is 0, which is disallowed), overriding load and count.
- REQ-028: Reset asserted mid-count SHALL take effect at the next edge with no residual wrap pulse; counting resumes on the first edge after reset deasserts.

Configuration
- REQ-029: Macro UPDOWN_MOD_COUNTER_WRAPCNT_EN SHALL, when defined, add output wrap_count (16 bits), incremented (modulo 2**16) on every edge producing wrap=1, cleared by reset, unaffected by load.
- REQ-030: Without UPDOWN_MOD_COUNTER_WRAPCNT_EN, wrap_count and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8, MAX_VALUE=9 unless noted)
- REQ-031: Reset 2 cycles, then enable=1, up=1, step=1 for 12 cycles -> counter 1..9,0,1,2; wrap=1 only on the cycle counter shows 0; at_max=1 while counter=9.
- REQ-032: load=1, load_value=200 with enable=1, up=1 -> counter=9 next cycle (clamped, load wins); then down=1, step=4 -> 5,1,7 with wrap=1 on 7.
- REQ-033: SATURATE=1: load 8, up, step=3 -> counter 9, wrap=1; next cycle stays 9, wrap=1; down, step=20 -> step clamped to 9 -> counter 0, wrap=0; again -> stays 0, wrap=1.
- REQ-034: up=down=1, enable=1, or enable=0 with up=1, from counter=4 -> counter holds 4, wrap=0 for all such cycles.
- REQ-035: Counter at 7 counting up; reset=1 for 1 cycle concurrent with load=1 -> counter=0, wrap=0; after deassert counting resumes 1,2.
- REQ-036: With UPDOWN_MOD_COUNTER_WRAPCNT_EN: 25 up-steps of step=1 from 0 -> wrap_count=2; reset -> wrap_count=0.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with a terminal count MAX_VALUE, a clamped step, and wrap or saturate overflow.
// Optional `define UPDOWN_MOD_COUNTER_WRAPCNT_EN adds a 16-bit wrap_count output.
module updown_mod_counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_VALUE = 2**WIDTH - 1,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] counter,
  output logic             at_max,
  output logic             at_min,
`ifdef UPDOWN_MOD_COUNTER_WRAPCNT_EN
  output logic [15:0]      wrap_count,
`endif
  output logic             wrap
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VALUE);
  localparam logic [WIDTH:0] MODULUS = (WIDTH+1)'(MAX_VALUE + 1);

  logic [WIDTH-1:0] counter_reg;
  logic [WIDTH-1:0] counter_next;
  logic             wrap_reg;
  logic             wrap_next;

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] load_ext;
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] step_eff;
  logic [WIDTH:0] up_sum;
  logic [WIDTH:0] down_wrapped;
  logic           count_req;
  logic           up_over;
  logic           down_under;

  // Everything is computed one bit wider than the counter so no sum or difference truncates.
  always_comb begin
    cnt_ext      = {1'b0, counter_reg};
    load_ext     = {1'b0, load_value};
    step_ext     = {1'b0, step};
    step_eff     = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
    up_sum       = cnt_ext + step_eff;
    down_wrapped = cnt_ext + MODULUS - step_eff;
    up_over      = up_sum > MAX_EXT;
    down_under   = step_eff > cnt_ext;
    count_req    = enable && (up ^ down) && (step_eff != '0);
  end

  always_comb begin
    counter_next = counter_reg;
    wrap_next    = 1'b0;
    if (load) begin
      counter_next = (load_ext > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : load_value;
    end else if (count_req) begin
      if (up) begin
        if (up_over) begin
          wrap_next = 1'b1;
          if (SATURATE != 0) begin
            counter_next = MAX_EXT[WIDTH-1:0];
          end else begin
            counter_next = WIDTH'(up_sum - MODULUS);
          end
        end else begin
          counter_next = up_sum[WIDTH-1:0];
        end
      end else begin
        if (down_under) begin
          wrap_next = 1'b1;
          if (SATURATE != 0) begin
            counter_next = '0;
          end else begin
            counter_next = down_wrapped[WIDTH-1:0];
          end
        end else begin
          counter_next = WIDTH'(cnt_ext - step_eff);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_reg <= '0;
      wrap_reg    <= 1'b0;
    end else begin
      counter_reg <= counter_next;
      wrap_reg    <= wrap_next;
    end
  end

  assign counter = counter_reg;
  assign wrap    = wrap_reg;
  assign at_max  = ({1'b0, counter_reg} == MAX_EXT);
  assign at_min  = (counter_reg == '0);

`ifdef UPDOWN_MOD_COUNTER_WRAPCNT_EN
  logic [15:0] wrap_count_reg;

  // Counts edges that produce a wrap pulse; load never produces one.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_count_reg <= '0;
    end else if (wrap_next) begin
      wrap_count_reg <= wrap_count_reg + 16'd1;
    end
  end

  assign wrap_count = wrap_count_reg;
`endif

endmodule
